// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: default geometry, requester
// indices and the owner tag that steers returning read data.
package ram_arbiter_pkg;

   localparam int RAM_AW = 9;
   localparam int RAM_DW = 8;

   localparam int OWNER_W = 1;
   typedef logic [OWNER_W-1:0] owner_t;

   localparam owner_t PORT_CPU = 1'b0;
   localparam owner_t PORT_VID = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Two-requester picker used once for reads and once for writes.
// RAM_ARB_RR_EN selects alternating winners; otherwise port 0 always wins.
module ram_arb_pick (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

`ifdef RAM_ARB_RR_EN
   // ptr_q names the port preferred in the next contest; it moves to the loser
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt0  = req0 & (~req1 | ~ptr_q);
      gnt1  = req1 & (~req0 | ptr_q);
      ptr_d = ptr_q;
      if (req0 && req1) begin
         ptr_d = ~ptr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_inputs;

   always_comb begin
      gnt0          = req0;
      gnt1          = req1 & ~req0;
      unused_inputs = clk ^ rst;
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU and a video requester onto one external dual-port block RAM.
// Define RAM_ARB_RR_EN for round-robin on same-type conflicts (default: port 0 wins).
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   logic   wr_req0, wr_req1, rd_req0, rd_req1;
   logic   wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
   logic   rd_elig0, rd_elig1;
   logic   rd_valid_d, rd_valid_q;
   owner_t rd_owner_d, rd_owner_q;

   // Requests are masked during reset so nothing is granted and no pointer moves
   always_comb begin
      wr_req0 = req0 & we0 & ~rst;
      wr_req1 = req1 & we1 & ~rst;
      rd_req0 = req0 & ~we0 & ~rst;
      rd_req1 = req1 & ~we1 & ~rst;
   end

   ram_arb_pick u_wr_pick (
      .clk  (clk),
      .rst  (rst),
      .req0 (wr_req0),
      .req1 (wr_req1),
      .gnt0 (wr_gnt0),
      .gnt1 (wr_gnt1)
   );

   // A read that hits the address being written this cycle waits one cycle
   always_comb begin
      rd_elig0 = rd_req0 & ~(wr_gnt1 & (addr1 == addr0));
      rd_elig1 = rd_req1 & ~(wr_gnt0 & (addr0 == addr1));
   end

   ram_arb_pick u_rd_pick (
      .clk  (clk),
      .rst  (rst),
      .req0 (rd_elig0),
      .req1 (rd_elig1),
      .gnt0 (rd_gnt0),
      .gnt1 (rd_gnt1)
   );

   always_comb begin
      gnt0       = wr_gnt0 | rd_gnt0;
      gnt1       = wr_gnt1 | rd_gnt1;
      ram_we     = wr_gnt0 | wr_gnt1;
      ram_waddr  = wr_gnt1 ? addr1 : addr0;
      ram_wdata  = wr_gnt1 ? wdata1 : wdata0;
      ram_re     = rd_gnt0 | rd_gnt1;
      ram_raddr  = rd_gnt1 ? addr1 : addr0;
      rd_valid_d = rd_gnt0 | rd_gnt1;
      rd_owner_d = rd_gnt1 ? PORT_VID : PORT_CPU;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_owner_q <= PORT_CPU;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // The owner tag travels with the read so RAM data lands at the right port
   always_comb begin
      rvalid0 = rd_valid_q & (rd_owner_q == PORT_CPU);
      rvalid1 = rd_valid_q & (rd_owner_q == PORT_VID);
      rdata0  = rvalid0 ? ram_rdata : '0;
      rdata1  = rvalid1 ? ram_rdata : '0;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 9, meaning RAM address width (512 words).
REQ-002 SHALL have parameter DW, default 8, meaning RAM data width.
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge; all state on clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports req0/req1, input, 1, request from requester 0/1 (0 = CPU, 1 = video).
REQ-006 SHALL have ports we0/we1, input, 1, request is a write (1) or a read (0).
REQ-007 SHALL have ports addr0/addr1, input, AW, request address.
REQ-008 SHALL have ports wdata0/wdata1, input, DW, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1, request accepted this cycle (combinational from inputs and state).
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1, read data valid, registered.
REQ-011 SHALL have ports rdata0/rdata1, output, DW, read data, meaningful only while matching rvalid is high.
REQ-012 SHALL have ports ram_re, ram_raddr[AW], ram_we, ram_waddr[AW], ram_wdata[DW] as outputs, ram_rdata[DW] as input, driving one external 512x8 block RAM (independent read and write ports, read data registered one cycle after ram_re).

Function
REQ-013 Requester SHALL hold req, we, addr and wdata stable until gnt; a transfer completes in the cycle gnt=1; a new request may follow in the next cycle.
REQ-014 Read grant and write grant SHALL be arbitrated independently: at most one read and at most one write issued per cycle.
REQ-015 One requester writing and the other reading in the same cycle SHALL both be granted, unless addresses are equal; then the write is granted and the read is held off one cycle.
REQ-016 Both requesters reading, or both writing, SHALL grant one only, chosen by the arbitration policy (REQ-025/026); the loser stays pending.
REQ-017 Granted read SHALL drive ram_re=1, ram_raddr=addr that cycle; granted write SHALL drive ram_we=1, ram_waddr=addr, ram_wdata=wdata that cycle; otherwise ram_re=ram_we=0.
REQ-018 rvalidN SHALL be 1 exactly one cycle after a read grant to requester N, with rdataN=ram_rdata; rvalid0 and rvalid1 SHALL never be high together.
REQ-019 A one-bit owner tag SHALL be registered with each issued read to route ram_rdata; back-to-back reads of alternating owners SHALL route correctly every cycle.
REQ-020 req=0 SHALL never produce gnt=1; gnt SHALL never assert for an idle requester.

Reset
REQ-021 While rst=1: gnt0=gnt1=0, rvalid0=rvalid1=0, ram_re=ram_we=0, rdata0=rdata1=0, round-robin pointer=0 (port 0 preferred).
REQ-022 A read granted in the cycle rst asserts SHALL NOT produce rvalid after rst deasserts.
REQ-023 First grant SHALL be possible in the first clk edge after rst deasserts.
REQ-024 Reset SHALL NOT alter RAM contents.

Configuration
REQ-025 With RAM_ARB_RR_EN defined: same-type conflicts SHALL alternate; a per-type (read, write) last-winner register flips on every contested grant; the loser wins the next contest.
REQ-026 Without RAM_ARB_RR_EN: port 0 SHALL always win same-type conflicts; last-winner registers SHALL not exist.

Structure
REQ-027 Shared package SHALL hold AW/DW defaults, port index constants (PORT_CPU=0, PORT_VID=1) and the owner-tag width.
REQ-028 Sub-module ram_arb_pick (two-requester priority/round-robin picker, one instance each for read and write) is natural; RAM instance stays outside the block.

Verification
REQ-029 req0 read addr 0x010 alone, RAM holds 0x5A -> gnt0 same cycle, rvalid0=1 with rdata0=0x5A one cycle later, rvalid1=0.
REQ-030 req0 write 0x020<=0xA5 and req1 read 0x021 same cycle -> both gnt, ram_we=1 and ram_re=1 same cycle.
REQ-031 req0 write 0x030<=0x11, req1 read 0x030 same cycle -> gnt0 only; gnt1 next cycle; rvalid1 with rdata1=0x11.
REQ-032 Both read continuously for 4 cycles, RR_EN defined -> grants 0,1,0,1; rvalids follow one cycle later in same order; undefined -> gnt0 all 4 cycles, gnt1=0.
REQ-033 rst pulsed in the cycle after a read grant -> no rvalid after release; outputs zero during reset; next request granted in first cycle after release.
REQ-034 Random mix of req/we/addr over 10000 cycles against a reference memory model -> every read returns last-written value, no lost or duplicated grant.
